// File: rtl/poly_sequencer.sv
// poly_sequencer: queues polynomial operand tuples, hands them one job at a
// time to an external control/datapath pair, and returns the result or a
// timeout-abort marker through a valid/ready output port.
// DEPTH must be a power of two and at least 2.
module poly_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_a,
  input  logic [15:0]              in_b,
  input  logic [15:0]              in_c,
  input  logic [15:0]              in_x,
  output logic [15:0]              A,
  output logic [15:0]              B,
  output logic [15:0]              C,
  output logic [15:0]              Xis,
  output logic                     w,
  input  logic                     done,
  input  logic [15:0]              resultado,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_data,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 2);
  localparam int unsigned TUPLE_W = 64;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);
  localparam logic [15:0]   ABORT_DATA = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_OUT
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                in_ready_q, in_ready_d;
  logic [15:0]         a_q, a_d;
  logic [15:0]         b_q, b_d;
  logic [15:0]         c_q, c_d;
  logic [15:0]         x_q, x_d;
  logic                w_q, w_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic                ov_q, ov_d;
  logic [15:0]         od_q, od_d;
  logic                oe_q, oe_d;

  logic                push;
  logic                pop;
  logic [TUPLE_W-1:0]  head;
  logic [TUPLE_W-1:0]  fifo_mem [DEPTH];

  assign head = fifo_mem[rd_ptr_q];

  // Tuple storage; contents are invalidated by the pointers on reset, not cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {in_a, in_b, in_c, in_x};
    end
  end

  // FIFO pointers and occupancy; in_ready is precomputed from the next count.
  always_comb begin
    push     = in_valid && in_ready_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d < DEPTH_C);
  end

  // Job sequencing: next state, operand capture, start pulse, result capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    x_d     = x_q;
    w_d     = 1'b0;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    od_d    = od_q;
    oe_d    = oe_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        pop                    = 1'b1;
        {a_d, b_d, c_d, x_d}   = head;
        // w is registered, so raising it here makes it high exactly in START.
        w_d                    = 1'b1;
        state_d                = S_START;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the same cycle as the timeout limit is a success.
        if (done) begin
          od_d    = resultado;
          oe_d    = 1'b0;
          ov_d    = 1'b1;
          state_d = S_OUT;
        end else if (cnt_q == TIMEOUT_C) begin
          od_d    = ABORT_DATA;
          oe_d    = 1'b1;
          ov_d    = 1'b1;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      x_q        <= '0;
      w_q        <= 1'b0;
      cnt_q      <= '0;
      ov_q       <= 1'b0;
      od_q       <= '0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      x_q        <= x_d;
      w_q        <= w_d;
      cnt_q      <= cnt_d;
      ov_q       <= ov_d;
      od_q       <= od_d;
      oe_q       <= oe_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign A         = a_q;
  assign B         = b_q;
  assign C         = c_q;
  assign Xis       = x_q;
  assign w         = w_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_err   = oe_q;
  assign occupancy = count_q;

endmodule
